// File: rtl/arp_table.sv
// ARP cache: fully associative IP -> MAC/netport table with learn, delete,
// aging and single-cycle registered lookups.
module arp_table #(
  parameter int unsigned DEPTH   = 16,
  parameter logic [7:0]  AGE_MAX = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rx_netport,
  input  logic [31:0] rx_ip,
  input  logic [47:0] rx_mac,
  input  logic        rx_en,
  input  logic        lk_req,
  input  logic [31:0] lk_ip,
  output logic        lk_ack,
  output logic        lk_hit,
  output logic [47:0] lk_mac,
  output logic [23:0] lk_netport,
  input  logic        age_tick,
  output logic [6:0]  entry_cnt,
  output logic        full
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [31:0]      ip_q  [DEPTH];
  logic [31:0]      ip_d  [DEPTH];
  logic [47:0]      mac_q [DEPTH];
  logic [47:0]      mac_d [DEPTH];
  logic [23:0]      np_q  [DEPTH];
  logic [23:0]      np_d  [DEPTH];
  logic [7:0]       age_q [DEPTH];
  logic [7:0]       age_d [DEPTH];
  logic [IDX_W-1:0] rptr_q, rptr_d;
  logic [6:0]       entry_cnt_q, entry_cnt_d;
  logic             lk_ack_q, lk_ack_d;
  logic             lk_hit_q, lk_hit_d;
  logic [47:0]      lk_mac_q, lk_mac_d;
  logic [23:0]      lk_np_q, lk_np_d;

  logic             rx_hit, free_found, lk_found;
  logic [IDX_W-1:0] rx_idx, free_idx, lk_idx, wr_idx;
  logic [6:0]       cnt;

  // Searches use pre-update state; aging applies first so an update always wins.
  always_comb begin
    valid_d    = valid_q;
    ip_d       = ip_q;
    mac_d      = mac_q;
    np_d       = np_q;
    age_d      = age_q;
    rptr_d     = rptr_q;
    rx_hit     = 1'b0;
    rx_idx     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    lk_found   = 1'b0;
    lk_idx     = '0;
    wr_idx     = '0;
    cnt        = '0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!rx_hit && valid_q[i] && (ip_q[i] == rx_ip)) begin
        rx_hit = 1'b1;
        rx_idx = IDX_W'(i);
      end
      if (!lk_found && valid_q[i] && (ip_q[i] == lk_ip)) begin
        lk_found = 1'b1;
        lk_idx   = IDX_W'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    if (age_tick) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          if (age_q[i] == AGE_MAX) valid_d[i] = 1'b0;
          else                     age_d[i]   = age_q[i] + 8'd1;
        end
      end
    end

    if (rx_en) begin
      if (rx_netport != 24'd0) begin
        if (rx_ip != 32'd0) begin
          if (rx_hit)          wr_idx = rx_idx;
          else if (free_found) wr_idx = free_idx;
          else begin
            wr_idx = rptr_q;
            rptr_d = rptr_q + IDX_W'(1);
          end
          valid_d[wr_idx] = 1'b1;
          ip_d[wr_idx]    = rx_ip;
          mac_d[wr_idx]   = rx_mac;
          np_d[wr_idx]    = rx_netport;
          age_d[wr_idx]   = 8'd0;
        end
      end else if (rx_hit) begin
        valid_d[rx_idx] = 1'b0;
      end
    end

    for (int unsigned i = 0; i < DEPTH; i++) cnt = cnt + 7'(valid_d[i]);
    entry_cnt_d = cnt;

    lk_ack_d = lk_req;
    lk_hit_d = lk_req && lk_found;
    lk_mac_d = (lk_req && lk_found) ? mac_q[lk_idx] : 48'd0;
    lk_np_d  = (lk_req && lk_found) ? np_q[lk_idx]  : 24'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      rptr_q      <= '0;
      entry_cnt_q <= '0;
      lk_ack_q    <= 1'b0;
      lk_hit_q    <= 1'b0;
      lk_mac_q    <= '0;
      lk_np_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ip_q[i]  <= '0;
        mac_q[i] <= '0;
        np_q[i]  <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      rptr_q      <= rptr_d;
      entry_cnt_q <= entry_cnt_d;
      lk_ack_q    <= lk_ack_d;
      lk_hit_q    <= lk_hit_d;
      lk_mac_q    <= lk_mac_d;
      lk_np_q     <= lk_np_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ip_q[i]  <= ip_d[i];
        mac_q[i] <= mac_d[i];
        np_q[i]  <= np_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  assign lk_ack     = lk_ack_q;
  assign lk_hit     = lk_hit_q;
  assign lk_mac     = lk_mac_q;
  assign lk_netport = lk_np_q;
  assign entry_cnt  = entry_cnt_q;
  assign full       = (entry_cnt_q == 7'(DEPTH));

endmodule

// File: tb/tb_arp_table.sv
// Bench for arp_table: directed scenarios plus randomized traffic against a
// slot-level reference model of the cache.
module tb_arp_table;

  localparam int DEPTH   = 16;
  localparam int AGE_MAX = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] rx_netport = '0;
  logic [31:0] rx_ip = '0;
  logic [47:0] rx_mac = '0;
  logic        rx_en = 1'b0;
  logic        lk_req = 1'b0;
  logic [31:0] lk_ip = '0;
  logic        lk_ack, lk_hit;
  logic [47:0] lk_mac;
  logic [23:0] lk_netport;
  logic        age_tick = 1'b0;
  logic [6:0]  entry_cnt;
  logic        full;

  int checks = 0;
  int failures = 0;

  arp_table #(.DEPTH(DEPTH), .AGE_MAX(8'(AGE_MAX))) dut (
    .clk(clk), .rst(rst),
    .rx_netport(rx_netport), .rx_ip(rx_ip), .rx_mac(rx_mac), .rx_en(rx_en),
    .lk_req(lk_req), .lk_ip(lk_ip),
    .lk_ack(lk_ack), .lk_hit(lk_hit), .lk_mac(lk_mac), .lk_netport(lk_netport),
    .age_tick(age_tick), .entry_cnt(entry_cnt), .full(full)
  );

  always #5 clk = ~clk;

  // Reference model: slot contents plus the round-robin victim slot.
  bit          m_valid [DEPTH];
  logic [31:0] m_ip    [DEPTH];
  logic [47:0] m_mac   [DEPTH];
  logic [23:0] m_np    [DEPTH];
  int          m_age   [DEPTH];
  int          m_victim;
  bit          e_ack, e_hit;
  logic [47:0] e_mac;
  logic [23:0] e_np;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic int m_find(input logic [31:0] ip);
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_ip[i] == ip) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_age[i] = 0;
    end
    m_victim = 0;
    e_ack = 0; e_hit = 0; e_mac = '0; e_np = '0;
  endtask

  task automatic model_update(input bit en, input logic [23:0] np, input logic [31:0] ip,
                              input logic [47:0] mac, input bit tick);
    int tgt = -1;
    int del = -1;
    int hit = m_find(ip);
    int freeslot = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) freeslot = i;
    if (en && np != 0 && ip != 0) begin
      if (hit >= 0) tgt = hit;
      else if (freeslot >= 0) tgt = freeslot;
      else begin
        tgt = m_victim;
        m_victim = (m_victim + 1) % DEPTH;
      end
    end else if (en && np == 0) begin
      del = hit;
    end
    if (tick)
      for (int i = 0; i < DEPTH; i++)
        if (m_valid[i]) begin
          if (m_age[i] == AGE_MAX) m_valid[i] = 1'b0;
          else m_age[i]++;
        end
    if (tgt >= 0) begin
      m_valid[tgt] = 1'b1; m_ip[tgt] = ip; m_mac[tgt] = mac; m_np[tgt] = np; m_age[tgt] = 0;
    end
    if (del >= 0) m_valid[del] = 1'b0;
  endtask

  // One clock: drive inputs, predict the lookup result, advance model; outputs valid at return.
  task automatic cyc(input bit en, input logic [23:0] np, input logic [31:0] ip,
                     input logic [47:0] mac, input bit req, input logic [31:0] lip, input bit tick);
    int h;
    rx_en = en; rx_netport = np; rx_ip = ip; rx_mac = mac;
    lk_req = req; lk_ip = lip; age_tick = tick;
    h = m_find(lip);
    e_ack = req;
    e_hit = req && (h >= 0);
    e_mac = e_hit ? m_mac[h] : 48'd0;
    e_np  = e_hit ? m_np[h]  : 24'd0;
    @(posedge clk);
    model_update(en, np, ip, mac, tick);
    #1;
    rx_en = 0; lk_req = 0; age_tick = 0;
  endtask

  task automatic idle(); cyc(0, '0, '0, '0, 0, '0, 0); endtask
  task automatic learn(input logic [31:0] ip, input logic [47:0] mac, input logic [23:0] np);
    cyc(1, np, ip, mac, 0, '0, 0);
  endtask
  task automatic lookup(input logic [31:0] ip); cyc(0, '0, '0, '0, 1, ip, 0); endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (entry_cnt !== 7'd0) begin failures++; $display("FAIL reset_cnt got %0d exp 0", entry_cnt); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if ({lk_ack, lk_hit} !== 2'b00 || lk_mac !== 48'd0 || lk_netport !== 24'd0) begin
      failures++; $display("FAIL reset_lk got ack=%b hit=%b mac=%h np=%h exp all 0", lk_ack, lk_hit, lk_mac, lk_netport); end
  endtask

  task automatic test_learn_lookup();
    learn(32'h0A000001, 48'h001122334455, 24'h000004);
    idle();
    lookup(32'h0A000001);
    checks++; if ({lk_ack, lk_hit} !== 2'b11) begin failures++; $display("FAIL learn_hit got ack=%b hit=%b exp 1 1", lk_ack, lk_hit); end
    checks++; if (lk_mac !== 48'h001122334455) begin failures++; $display("FAIL learn_mac got %h exp 001122334455", lk_mac); end
    checks++; if (lk_netport !== 24'h000004) begin failures++; $display("FAIL learn_np got %h exp 000004", lk_netport); end
    checks++; if (entry_cnt !== 7'd1) begin failures++; $display("FAIL learn_cnt got %0d exp 1", entry_cnt); end
    idle();
    checks++; if ({lk_ack, lk_hit} !== 2'b00 || lk_mac !== 48'd0) begin
      failures++; $display("FAIL ack_oneshot got ack=%b hit=%b mac=%h exp 0", lk_ack, lk_hit, lk_mac); end
  endtask

  task automatic test_relearn_delete();
    learn(32'h0A000001, 48'hAABBCCDDEEFF, 24'h000200);
    lookup(32'h0A000001);
    checks++; if (lk_hit !== 1'b1 || lk_mac !== 48'hAABBCCDDEEFF || lk_netport !== 24'h000200) begin
      failures++; $display("FAIL relearn got hit=%b mac=%h np=%h exp 1 aabbccddeeff 000200", lk_hit, lk_mac, lk_netport); end
    checks++; if (entry_cnt !== 7'd1) begin failures++; $display("FAIL relearn_cnt got %0d exp 1", entry_cnt); end
    learn(32'h0A000001, 48'h0, 24'h0);
    lookup(32'h0A000001);
    checks++; if ({lk_ack, lk_hit} !== 2'b10 || lk_mac !== 48'd0 || lk_netport !== 24'd0) begin
      failures++; $display("FAIL delete_miss got ack=%b hit=%b mac=%h np=%h exp 1 0 0 0", lk_ack, lk_hit, lk_mac, lk_netport); end
    checks++; if (entry_cnt !== 7'd0) begin failures++; $display("FAIL delete_cnt got %0d exp 0", entry_cnt); end
    learn(32'h0A000099, 48'h0, 24'h0);
    checks++; if (entry_cnt !== 7'd0) begin failures++; $display("FAIL delete_nomatch got %0d exp 0", entry_cnt); end
  endtask

  task automatic test_full_replace();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) learn(32'h0B000000 + 32'(i), 48'h100 + 48'(i), 24'h000001 << (i % 24));
    checks++; if (full !== 1'b1 || entry_cnt !== 7'(DEPTH)) begin
      failures++; $display("FAIL full got full=%b cnt=%0d exp 1 %0d", full, entry_cnt, DEPTH); end
    learn(32'h0B000011, 48'hDEAD, 24'h800000);
    lookup(32'h0B000001);
    checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL replaced_miss got %b exp 0", lk_hit); end
    lookup(32'h0B000011);
    checks++; if (lk_hit !== 1'b1 || lk_mac !== 48'hDEAD) begin
      failures++; $display("FAIL replacer_hit got hit=%b mac=%h exp 1 dead", lk_hit, lk_mac); end
    lookup(32'h0B000002);
    checks++; if (lk_hit !== 1'b1) begin failures++; $display("FAIL survivor_hit got %b exp 1", lk_hit); end
    checks++; if (entry_cnt !== 7'd16) begin failures++; $display("FAIL replace_cnt got %0d exp 16", entry_cnt); end
  endtask

  task automatic test_aging();
    do_reset();
    learn(32'h0C000001, 48'h1, 24'h000010);
    for (int i = 0; i < AGE_MAX; i++) cyc(0, '0, '0, '0, 0, '0, 1);
    checks++; if (entry_cnt !== 7'd1) begin failures++; $display("FAIL age_alive got %0d exp 1", entry_cnt); end
    cyc(0, '0, '0, '0, 0, '0, 1);
    lookup(32'h0C000001);
    checks++; if (lk_hit !== 1'b0 || entry_cnt !== 7'd0) begin
      failures++; $display("FAIL age_expire got hit=%b cnt=%0d exp 0 0", lk_hit, entry_cnt); end
    learn(32'h0C000002, 48'h2, 24'h000020);
    for (int i = 0; i < AGE_MAX; i++) cyc(0, '0, '0, '0, 0, '0, 1);
    cyc(1, 24'h000040, 32'h0C000002, 48'h3, 0, '0, 1);
    lookup(32'h0C000002);
    checks++; if (lk_hit !== 1'b1 || lk_netport !== 24'h000040 || entry_cnt !== 7'd1) begin
      failures++; $display("FAIL refresh_tick got hit=%b np=%h cnt=%0d exp 1 000040 1", lk_hit, lk_netport, entry_cnt); end
    for (int i = 0; i < AGE_MAX; i++) cyc(0, '0, '0, '0, 0, '0, 1);
    checks++; if (entry_cnt !== 7'd1) begin failures++; $display("FAIL refresh_age0 got %0d exp 1", entry_cnt); end
    cyc(0, '0, '0, '0, 0, '0, 1);
    checks++; if (entry_cnt !== 7'd0) begin failures++; $display("FAIL refresh_expire got %0d exp 0", entry_cnt); end
  endtask

  task automatic test_same_cycle();
    cyc(1, 24'h000008, 32'h0A000007, 48'h777, 1, 32'h0A000007, 0);
    checks++; if ({lk_ack, lk_hit} !== 2'b10) begin failures++; $display("FAIL same_cycle got ack=%b hit=%b exp 1 0", lk_ack, lk_hit); end
    lookup(32'h0A000007);
    checks++; if (lk_hit !== 1'b1 || lk_mac !== 48'h777) begin
      failures++; $display("FAIL next_cycle got hit=%b mac=%h exp 1 777", lk_hit, lk_mac); end
  endtask

  task automatic test_reset_mid();
    learn(32'h0D000001, 48'h11, 24'h000001);
    learn(32'h0D000002, 48'h22, 24'h000002);
    learn(32'h0D000003, 48'h33, 24'h000004);
    rst = 1'b1; lk_req = 1'b1; lk_ip = 32'h0D000001;
    @(posedge clk); #1;
    lk_req = 1'b0; rst = 1'b0;
    model_reset();
    checks++; if (lk_ack !== 1'b0 || entry_cnt !== 7'd0) begin
      failures++; $display("FAIL reset_mid got ack=%b cnt=%0d exp 0 0", lk_ack, entry_cnt); end
    idle();
    checks++; if (lk_ack !== 1'b0) begin failures++; $display("FAIL reset_noack got %b exp 0", lk_ack); end
    for (int i = 1; i <= 3; i++) begin
      lookup(32'h0D000000 + 32'(i));
      checks++; if ({lk_ack, lk_hit} !== 2'b10) begin
        failures++; $display("FAIL reset_lookup%0d got ack=%b hit=%b exp 1 0", i, lk_ack, lk_hit); end
    end
    learn(32'h0E000001, 48'h5, 24'h000002);
    learn(32'h0, 48'h6, 24'h000002);
    checks++; if (entry_cnt !== 7'd1) begin failures++; $display("FAIL ip0_dropped got %0d exp 1", entry_cnt); end
    lookup(32'h0);
    checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL ip0_lookup got %b exp 0", lk_hit); end
  endtask

  task automatic test_random();
    logic [23:0] np;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      np = ($urandom_range(0, 4) == 0) ? 24'd0 : (24'd1 << $urandom_range(0, 23));
      cyc(($urandom_range(0, 2) != 0), np, 32'($urandom_range(0, 22)), {16'd0, 32'($urandom)},
          ($urandom_range(0, 1) == 1), 32'($urandom_range(0, 22)), ($urandom_range(0, 5) == 0));
      checks++; if (lk_ack !== e_ack || lk_hit !== e_hit || lk_mac !== e_mac || lk_netport !== e_np) begin
        failures++; $display("FAIL rand_lk n=%0d got %b %b %h %h exp %b %b %h %h", n,
                             lk_ack, lk_hit, lk_mac, lk_netport, e_ack, e_hit, e_mac, e_np); end
      checks++; if (entry_cnt !== 7'(m_count()) || full !== (m_count() == DEPTH)) begin
        failures++; $display("FAIL rand_cnt n=%0d got cnt=%0d full=%b exp %0d", n, entry_cnt, full, m_count()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_learn_lookup();
    test_relearn_delete();
    test_full_replace();
    test_aging();
    do_reset();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
